// File: rtl/pe_pkg.sv
// pe_pkg: state encoding and default sizing shared by the pe_row systolic row.
package pe_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ACC_W  = 32;
  localparam int DEF_NUM_PE = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Drain pointer width; at least one bit so a single-PE row still has a pointer.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pe_cell.sv
// pe_cell: one processing element of the row. Registers the row and column
// operands (with their valids) for the neighbouring PEs and accumulates
// row*col into a private accumulator.
// Build option: PE_ROW_SAT_EN clamps overflowing MACs instead of wrapping.
module pe_cell
  import pe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              signed_mode,
  input  logic              freeze,
  input  logic              clr,
  input  logic              zero_acc,
  input  logic [DATA_W-1:0] row,
  input  logic              row_vld,
  input  logic [DATA_W-1:0] col,
  input  logic              col_vld,
  output logic [DATA_W-1:0] row_p1,
  output logic              row_vld_p1,
  output logic [DATA_W-1:0] col_p1,
  output logic              col_vld_p1,
  output logic [ACC_W-1:0]  acc_p1,
  output logic              mac,
  output logic              mac_ovf
);

  logic signed [2*DATA_W-1:0] prod_s;
  logic        [2*DATA_W-1:0] prod_u;
  logic signed [ACC_W:0]      addend;
  logic signed [ACC_W:0]      base;
  logic signed [ACC_W:0]      sum;
  logic                       ovf_hit;
  logic        [ACC_W-1:0]    acc_nxt;

`ifdef PE_ROW_SAT_EN
  // Clamp an ACC_W+1 bit exact sum back into the ACC_W range of the current mode.
  function automatic logic [ACC_W-1:0] sat_acc(input logic signed [ACC_W:0] s,
                                               input logic sm);
    logic [ACC_W-1:0] res;
    res = s[ACC_W-1:0];
    if (sm) begin
      if (s[ACC_W] != s[ACC_W-1])
        res = s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else if (s[ACC_W]) begin
      res = '1;
    end
    return res;
  endfunction
`endif

  // Products are formed at full 2*DATA_W precision so neither mode can truncate.
  assign prod_s = $signed({{DATA_W{row[DATA_W-1]}}, row}) * $signed({{DATA_W{col[DATA_W-1]}}, col});
  assign prod_u = {{DATA_W{1'b0}}, row} * {{DATA_W{1'b0}}, col};

  // One extra sum bit makes overflow detection exact for both signed and unsigned modes.
  assign addend  = signed_mode ? {{(ACC_W+1-2*DATA_W){prod_s[2*DATA_W-1]}}, prod_s}
                               : {{(ACC_W+1-2*DATA_W){1'b0}}, prod_u};
  assign base    = clr ? '0 : (signed_mode ? {acc_p1[ACC_W-1], acc_p1} : {1'b0, acc_p1});
  assign sum     = base + addend;
  assign ovf_hit = signed_mode ? (sum[ACC_W] ^ sum[ACC_W-1]) : sum[ACC_W];

  assign mac     = row_vld & col_vld & ~freeze;
  assign mac_ovf = mac & ovf_hit;

`ifdef PE_ROW_SAT_EN
  assign acc_nxt = sat_acc(sum, signed_mode);
`else
  assign acc_nxt = sum[ACC_W-1:0];
`endif

  // Stage p1: operand/valid forwarding registers and the accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_p1     <= '0;
      row_vld_p1 <= 1'b0;
      col_p1     <= '0;
      col_vld_p1 <= 1'b0;
      acc_p1     <= '0;
    end else begin
      if (!freeze) begin
        row_p1 <= row;
        col_p1 <= col;
      end
      row_vld_p1 <= row_vld & ~freeze;
      col_vld_p1 <= col_vld & ~freeze;
      if (zero_acc)
        acc_p1 <= '0;
      else if (mac)
        acc_p1 <= acc_nxt;
      else if (clr)
        acc_p1 <= '0;
    end
  end

endmodule

// File: rtl/pe_row.sv
// pe_row: a cascade of NUM_PE pe_cells. Row operands ripple west to east one
// PE per cycle; each PE takes its own column operand from the north. A small
// FSM freezes the array and reads the accumulators out one per handshake.
// Build option: PE_ROW_SAT_EN makes accumulators saturate instead of wrap.
module pe_row
  import pe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int NUM_PE = DEF_NUM_PE
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        west_row_in,
  input  logic                     west_valid_in,
  input  logic [NUM_PE*DATA_W-1:0] north_col_in,
  input  logic [NUM_PE-1:0]        north_valid_in,
  output logic [DATA_W-1:0]        east_row_out,
  output logic                     east_valid_out,
  output logic [NUM_PE*DATA_W-1:0] south_col_out,
  output logic [NUM_PE-1:0]        south_valid_out,
  input  logic                     signed_mode,
  input  logic                     clear,
  input  logic                     drain_req,
  output logic [ACC_W-1:0]         result_out,
  output logic                     result_valid,
  input  logic                     result_ready,
  output logic                     busy,
  output logic                     ovf
);

  localparam int               PTR_W    = ptr_width(NUM_PE);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_PE - 1);

  state_t            state_p1;
  logic [PTR_W-1:0]  ptr_p1;
  logic              ovf_p1;
  logic              draining;
  logic              clr_acc;
  logic              hs_last;
  logic [DATA_W-1:0] row_chain [NUM_PE+1];
  logic [NUM_PE:0]   vld_chain;
  logic [NUM_PE-1:0] col_vld_p1;
  logic [NUM_PE-1:0] mac;
  logic [NUM_PE-1:0] mac_ovf;
  logic [NUM_PE-1:0] zero_acc;
  logic [ACC_W-1:0]  acc_p1 [NUM_PE];

  assign draining     = (state_p1 == ST_DRAIN);
  assign clr_acc      = clear & ~draining;
  assign hs_last      = draining & result_ready & (ptr_p1 == LAST_PTR);
  assign row_chain[0] = west_row_in;
  assign vld_chain[0] = west_valid_in;

  for (genvar k = 0; k < NUM_PE; k++) begin : g_pe
    // The accumulator being read out is zeroed on its handshake.
    assign zero_acc[k] = draining & result_ready & (ptr_p1 == PTR_W'(k));

    pe_cell #(
      .DATA_W(DATA_W),
      .ACC_W (ACC_W)
    ) u_pe (
      .clk        (clk),
      .rst        (rst),
      .signed_mode(signed_mode),
      .freeze     (draining),
      .clr        (clr_acc),
      .zero_acc   (zero_acc[k]),
      .row        (row_chain[k]),
      .row_vld    (vld_chain[k]),
      .col        (north_col_in[k*DATA_W +: DATA_W]),
      .col_vld    (north_valid_in[k]),
      .row_p1     (row_chain[k+1]),
      .row_vld_p1 (vld_chain[k+1]),
      .col_p1     (south_col_out[k*DATA_W +: DATA_W]),
      .col_vld_p1 (col_vld_p1[k]),
      .acc_p1     (acc_p1[k]),
      .mac        (mac[k]),
      .mac_ovf    (mac_ovf[k])
    );
  end

  // Valids may already be in flight on the cycle DRAIN is entered, so mask them here.
  assign east_row_out    = row_chain[NUM_PE];
  assign east_valid_out  = vld_chain[NUM_PE] & ~draining;
  assign south_valid_out = col_vld_p1 & {NUM_PE{~draining}};
  assign result_out      = acc_p1[ptr_p1];
  assign result_valid    = draining;
  assign busy            = (state_p1 != ST_IDLE);
  assign ovf             = ovf_p1;

  // Control FSM: accumulate, then drain one accumulator per handshake; sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p1 <= ST_IDLE;
      ptr_p1   <= '0;
      ovf_p1   <= 1'b0;
    end else begin
      case (state_p1)
        ST_IDLE: begin
          if (drain_req)
            state_p1 <= ST_DRAIN;
          else if (|mac)
            state_p1 <= ST_ACCUM;
        end
        ST_ACCUM: begin
          if (drain_req)
            state_p1 <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (hs_last) begin
            state_p1 <= ST_IDLE;
            ptr_p1   <= '0;
          end else if (result_ready) begin
            ptr_p1 <= ptr_p1 + PTR_W'(1);
          end
        end
        default: state_p1 <= ST_IDLE;
      endcase

      if (draining) begin
        if (hs_last)
          ovf_p1 <= 1'b0;
      end else if (clear) begin
        ovf_p1 <= 1'b0;
      end else if (|mac_ovf) begin
        ovf_p1 <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pe_row.sv
// tb_pe_row: directed scenarios plus randomized bursts for pe_row, checked
// against a cycle-level behavioural model of the row held in the bench.
module tb_pe_row;

  localparam int DW = 8;
  localparam int AW = 32;
  localparam int N  = 4;
  localparam longint SMAX = (longint'(1) << (AW-1)) - 1;
  localparam longint SMIN = -(longint'(1) << (AW-1));
  localparam longint UMAX = (longint'(1) << AW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, signed_mode, clear, drain_req, result_ready;
  logic [DW-1:0]   west_row_in;
  logic            west_valid_in;
  logic [N*DW-1:0] north_col_in;
  logic [N-1:0]    north_valid_in;

  logic [DW-1:0]   east_row_out;
  logic            east_valid_out;
  logic [N*DW-1:0] south_col_out;
  logic [N-1:0]    south_valid_out;
  logic [AW-1:0]   result_out;
  logic            result_valid, busy, ovf;

  logic [DW-1:0]   east_row_16;
  logic            east_valid_16;
  logic [N*DW-1:0] south_col_16;
  logic [N-1:0]    south_valid_16;
  logic [15:0]     result_out_16;
  logic            result_valid_16, busy_16, ovf_16;

  pe_row #(.DATA_W(DW), .ACC_W(AW), .NUM_PE(N)) dut (
    .clk(clk), .rst(rst), .west_row_in(west_row_in), .west_valid_in(west_valid_in),
    .north_col_in(north_col_in), .north_valid_in(north_valid_in),
    .east_row_out(east_row_out), .east_valid_out(east_valid_out),
    .south_col_out(south_col_out), .south_valid_out(south_valid_out),
    .signed_mode(signed_mode), .clear(clear), .drain_req(drain_req),
    .result_out(result_out), .result_valid(result_valid), .result_ready(result_ready),
    .busy(busy), .ovf(ovf));

  pe_row #(.DATA_W(DW), .ACC_W(16), .NUM_PE(N)) dut16 (
    .clk(clk), .rst(rst), .west_row_in(west_row_in), .west_valid_in(west_valid_in),
    .north_col_in(north_col_in), .north_valid_in(north_valid_in),
    .east_row_out(east_row_16), .east_valid_out(east_valid_16),
    .south_col_out(south_col_16), .south_valid_out(south_valid_16),
    .signed_mode(signed_mode), .clear(clear), .drain_req(drain_req),
    .result_out(result_out_16), .result_valid(result_valid_16), .result_ready(result_ready),
    .busy(busy_16), .ovf(ovf_16));

  int tests = 0;
  int fails = 0;

  // Reference model: accumulator values, drain pointer, overflow flag, phase
  // (0 idle, 1 accumulating, 2 draining), row history and last column inputs.
  longint        macc [N];
  int            mptr, mst;
  bit            movf;
  bit            hv [N];
  logic [DW-1:0] hd [N];
  bit            pv [N];
  logic [DW-1:0] pd [N];
  logic [AW-1:0] ex [N];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    west_row_in    = '0;
    west_valid_in  = 1'b0;
    north_col_in   = '0;
    north_valid_in = '0;
    clear          = 1'b0;
    drain_req      = 1'b0;
    result_ready   = 1'b0;
  endtask

  task automatic model_step();
    bit            any, anyo, rv;
    logic [DW-1:0] rd, cd;
    longint        p, s;
    bit            o;
    any  = 0;
    anyo = 0;
    if (rst) begin
      for (int k = 0; k < N; k++) begin
        macc[k] = 0; hv[k] = 0; hd[k] = '0; pv[k] = 0; pd[k] = '0;
      end
      mptr = 0; movf = 0; mst = 0;
    end else if (mst == 2) begin
      if (result_ready) begin
        macc[mptr] = 0;
        if (mptr == N-1) begin mst = 0; mptr = 0; movf = 0; end
        else mptr++;
      end
      for (int k = 0; k < N; k++) begin hv[k] = 0; pv[k] = 0; end
    end else begin
      for (int k = 0; k < N; k++) begin
        rv = (k == 0) ? west_valid_in : hv[k-1];
        rd = (k == 0) ? west_row_in : hd[k-1];
        cd = north_col_in[k*DW +: DW];
        if (rv && north_valid_in[k]) begin
          any = 1;
          p = signed_mode ? longint'($signed(rd)) * longint'($signed(cd)) : longint'(rd) * longint'(cd);
          s = (clear ? 0 : macc[k]) + p;
          o = signed_mode ? (s > SMAX || s < SMIN) : (s > UMAX);
          if (o) begin
            anyo = 1;
`ifdef PE_ROW_SAT_EN
            s = signed_mode ? ((s > SMAX) ? SMAX : SMIN) : UMAX;
`else
            s = s & UMAX;
            if (signed_mode && s > SMAX) s = s - (UMAX + 1);
`endif
          end
          macc[k] = s;
        end else if (clear) begin
          macc[k] = 0;
        end
      end
      if (clear) movf = 0;
      else if (anyo) movf = 1;
      if (drain_req) mst = 2;
      else if (mst == 0 && any) mst = 1;
      for (int k = N-1; k > 0; k--) begin hv[k] = hv[k-1]; hd[k] = hd[k-1]; end
      hv[0] = west_valid_in;
      hd[0] = west_row_in;
      for (int k = 0; k < N; k++) begin
        pv[k] = north_valid_in[k];
        pd[k] = north_col_in[k*DW +: DW];
      end
    end
  endtask

  task automatic check_outputs();
    bit ev, sv;
    chk("busy", 64'(busy), 64'(mst != 0));
    chk("result_valid", 64'(result_valid), 64'(mst == 2));
    chk("ovf", 64'(ovf), 64'(movf));
    ev = hv[N-1] && (mst != 2);
    chk("east_valid", 64'(east_valid_out), 64'(ev));
    if (ev) chk("east_row", 64'(east_row_out), 64'(hd[N-1]));
    for (int k = 0; k < N; k++) begin
      sv = pv[k] && (mst != 2);
      chk("south_valid", 64'(south_valid_out[k]), 64'(sv));
      if (sv) chk("south_col", 64'(south_col_out[k*DW +: DW]), 64'(pd[k]));
    end
    if (mst == 2) chk("result_out", 64'(result_out), 64'(macc[mptr][AW-1:0]));
  endtask

  task automatic cyc();
    check_outputs();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic burst(input int n, input bit sm);
    signed_mode = sm;
    for (int i = 0; i < n; i++) begin
      west_row_in    = DW'($urandom);
      west_valid_in  = 1'($urandom);
      north_col_in   = (N*DW)'($urandom);
      north_valid_in = N'($urandom);
      clear          = ($urandom_range(19) == 0);
      cyc();
    end
    idle_inputs();
    for (int i = 0; i <= N; i++) cyc();
  endtask

  task automatic drain_rand(input int stall_pct);
    int guard;
    guard = 0;
    drain_req = 1'b1;
    cyc();
    drain_req = 1'b0;
    while (busy && guard < 100) begin
      result_ready = ($urandom_range(99) >= stall_pct);
      cyc();
      guard++;
    end
    result_ready = 1'b0;
    chk("drain_bounded", 64'(guard < 100), 64'(1));
  endtask

  task automatic drain_check(input string tag);
    drain_req = 1'b1;
    cyc();
    drain_req = 1'b0;
    result_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      chk(tag, 64'(result_out), 64'(ex[i]));
      cyc();
    end
    result_ready = 1'b0;
    chk({tag, "_busy"}, 64'(busy), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout tests=%0d", tests);
    $fatal(1, "timeout");
  end

  initial begin
    logic [AW-1:0] held;
    logic [15:0]   exp16;

    // Reset
    idle_inputs();
    signed_mode = 1'b0;
    rst = 1'b1;
    model_step(); @(posedge clk); #1;
    model_step(); @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_result_valid", 64'(result_valid), 64'(0));
    chk("rst_result_out", 64'(result_out), 64'(0));
    chk("rst_ovf", 64'(ovf), 64'(0));
    chk("rst_east_valid", 64'(east_valid_out), 64'(0));
    chk("rst_east_row", 64'(east_row_out), 64'(0));
    chk("rst_south_valid", 64'(south_valid_out), 64'(0));
    chk("rst_south_col", 64'(south_col_out), 64'(0));

    // Signed wavefront: west=3 once, north 2,-1,4,5 on successive cycles
    signed_mode = 1'b1;
    west_row_in = 8'd3; west_valid_in = 1'b1;
    north_col_in = 32'h0000_0002; north_valid_in = 4'b0001;
    cyc();
    west_valid_in = 1'b0; west_row_in = '0;
    north_col_in = 32'h0000_FF00; north_valid_in = 4'b0010;
    cyc();
    north_col_in = 32'h0004_0000; north_valid_in = 4'b0100;
    cyc();
    chk("wave_east_early", 64'(east_valid_out), 64'(0));
    north_col_in = 32'h0500_0000; north_valid_in = 4'b1000;
    cyc();
    chk("wave_east_valid", 64'(east_valid_out), 64'(1));
    chk("wave_east_row", 64'(east_row_out), 64'(3));
    idle_inputs();
    cyc();
    chk("wave_east_pulse", 64'(east_valid_out), 64'(0));
    ex = '{32'd6, 32'hFFFF_FFFD, 32'd12, 32'd15};
    drain_check("wave_result");

    // Unsigned 255*255 three times in PE 0
    clear = 1'b1; cyc(); clear = 1'b0;
    signed_mode = 1'b0;
    west_row_in = 8'd255; west_valid_in = 1'b1;
    north_col_in = 32'h0000_00FF; north_valid_in = 4'b0001;
    for (int i = 0; i < 3; i++) cyc();
    idle_inputs();
    for (int i = 0; i <= N; i++) cyc();
    chk("u255_ovf", 64'(ovf), 64'(0));
    ex = '{32'd195075, 32'd0, 32'd0, 32'd0};
    drain_check("u255_result");

    // Signed 127*127 three times: overflows only the 16-bit accumulator
    clear = 1'b1; cyc(); clear = 1'b0;
    signed_mode = 1'b1;
    west_row_in = 8'd127; west_valid_in = 1'b1;
    north_col_in = 32'h0000_007F; north_valid_in = 4'b0001;
    for (int i = 0; i < 3; i++) cyc();
    idle_inputs();
    for (int i = 0; i <= N; i++) cyc();
    chk("s127_ovf16", 64'(ovf_16), 64'(1));
    chk("s127_ovf32", 64'(ovf), 64'(0));
`ifdef PE_ROW_SAT_EN
    exp16 = 16'h7FFF;
`else
    exp16 = 16'hBD03;
`endif
    drain_req = 1'b1; cyc(); drain_req = 1'b0;
    chk("s127_result16", 64'(result_out_16), 64'(exp16));
    chk("s127_result32", 64'(result_out), 64'(48387));
    result_ready = 1'b1;
    for (int i = 0; i < N; i++) cyc();
    result_ready = 1'b0;
    chk("s127_ovf16_exit", 64'(ovf_16), 64'(0));
    chk("s127_busy16", 64'(busy_16), 64'(0));

    // Randomized bursts in both modes, drained with random back-pressure
    burst(40, 1'b1);
    drain_rand(30);
    burst(40, 1'b0);
    drain_rand(30);

    // Stalled drain holds result_out, then a second drain reads zeros
    burst(20, 1'b1);
    drain_req = 1'b1; cyc(); drain_req = 1'b0;
    held = result_out;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall_hold", 64'(result_out), 64'(held));
      chk("stall_busy", 64'(busy), 64'(1));
    end
    result_ready = 1'b1;
    for (int i = 0; i < N; i++) cyc();
    result_ready = 1'b0;
    chk("stall_done_busy", 64'(busy), 64'(0));
    ex = '{32'd0, 32'd0, 32'd0, 32'd0};
    drain_check("second_drain_zero");

    // clear coinciding with a 2*5 MAC in PE 1
    burst(16, 1'b1);
    west_row_in = 8'd2; west_valid_in = 1'b1;
    cyc();
    west_valid_in = 1'b0; west_row_in = '0;
    north_col_in = 32'h0000_0500; north_valid_in = 4'b0010; clear = 1'b1;
    cyc();
    idle_inputs();
    cyc();
    ex = '{32'd0, 32'd10, 32'd0, 32'd0};
    drain_check("clear_mac");

    // Reset in the middle of a drain at ptr=2
    burst(12, 1'b1);
    drain_req = 1'b1; cyc(); drain_req = 1'b0;
    result_ready = 1'b1;
    cyc(); cyc();
    result_ready = 1'b0;
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("middrain_rst_busy", 64'(busy), 64'(0));
    chk("middrain_rst_rvalid", 64'(result_valid), 64'(0));
    ex = '{32'd0, 32'd0, 32'd0, 32'd0};
    drain_check("middrain_rst_zero");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
